// File: rtl/rv32_mem_top.sv
// rv32_mem_top -- RV32 memory stage: issues data-bus accesses for LOAD/STORE,
// stalls the pipeline while a bus access is outstanding, and registers the
// result into the MEM/WB pipeline register.
//
// Ports:
//   clk, reset (async, active-low)
//   EX inputs    : valid_in, pc_in, iw_in, alu_in, rs2_data_in, wb_reg_in, wb_enable_in
//   Data bus     : dbus_req/we/io/addr/be/wdata (out), dbus_ack/rdata (in)
//   WB outputs   : pc_out, iw_out, alu_out, mem_rdata_out, io_rdata_out,
//                  wb_reg_out, wb_enable_out, wb_src_out (00 ALU, 01 mem, 10 IO)
//   stall_out    : holds EX and earlier stages while an access waits for ack
//   Forwarding   : df_mem_enable, df_mem_reg, df_mem_data, df_mem_is_load
//   Misalignment : misalign_out, misalign_addr
//
// Build option RV32_MEM_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
// accesses are suppressed and reported via misalign_out/misalign_addr; when
// undefined they issue normally and the misalign outputs are tied to 0.
module rv32_mem_top (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  wb_reg_in,
    input  logic        wb_enable_in,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic        dbus_io,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] alu_out,
    output logic [31:0] mem_rdata_out,
    output logic [31:0] io_rdata_out,
    output logic [4:0]  wb_reg_out,
    output logic        wb_enable_out,
    output logic [1:0]  wb_src_out,
    output logic        stall_out,
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data,
    output logic        df_mem_is_load,
    output logic        misalign_out,
    output logic [31:0] misalign_addr
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;

    logic        is_load, is_store, mem_op, is_io, misaligned, access;
    logic        in_access;
    logic [1:0]  size;
    logic [3:0]  be;

    logic [31:0] pc_d, pc_q;
    logic [31:0] iw_d, iw_q;
    logic [31:0] alu_d, alu_q;
    logic [31:0] mem_rdata_d, mem_rdata_q;
    logic [31:0] io_rdata_d, io_rdata_q;
    logic [4:0]  wb_reg_d, wb_reg_q;
    logic        wb_enable_d, wb_enable_q;
    logic [1:0]  wb_src_d, wb_src_q;

    // ---------------- decode ----------------
    always_comb begin
        is_load  = (iw_in[6:0] == OPC_LOAD);
        is_store = (iw_in[6:0] == OPC_STORE);
        mem_op   = valid_in & (is_load | is_store);
        is_io    = alu_in[31];
        size     = iw_in[13:12];   // 00 byte, 01 half, 1x word
`ifdef RV32_MEM_MISALIGN_TRAP_EN
        misaligned = mem_op & (((size == 2'b01) & alu_in[0]) |
                               (size[1] & (alu_in[1:0] != 2'b00)));
`else
        misaligned = 1'b0;
`endif
        access = mem_op & ~misaligned;

        case (size)
            2'b00:   be = 4'b0001 << alu_in[1:0];
            2'b01:   be = 4'b0011 << {alu_in[1], 1'b0};
            default: be = 4'b1111;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (access && !dbus_ack) state_d = S_WAIT;
            S_WAIT:  if (dbus_ack)            state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request is gated by reset so an aborted access drops dbus_req at once,
    // even though EX may still present the memory instruction.
    always_comb begin
        in_access  = (state_q == S_WAIT) | access;
        dbus_req   = reset & in_access;
        stall_out  = dbus_req & ~dbus_ack;
        dbus_we    = valid_in & is_store;
        dbus_io    = mem_op & is_io;
        dbus_addr  = {alu_in[31:2], 2'b00};
        dbus_be    = mem_op ? be : 4'b0000;
        dbus_wdata = '0;
        if (valid_in && is_store) begin
            case (size)
                2'b00:   dbus_wdata = {4{rs2_data_in[7:0]}};
                2'b01:   dbus_wdata = {2{rs2_data_in[15:0]}};
                default: dbus_wdata = rs2_data_in;
            endcase
        end
    end

    // ---------------- forwarding ----------------
    always_comb begin
        df_mem_enable  = valid_in & wb_enable_in & (wb_reg_in != 5'd0);
        df_mem_reg     = wb_reg_in;
        df_mem_data    = alu_in;
        df_mem_is_load = valid_in & is_load;
    end

    // ---------------- WB register ----------------
    // A valid, unstalled memory instruction can only get here with dbus_ack
    // high, so dbus_rdata is valid whenever it is captured.
    always_comb begin
        pc_d        = '0;
        iw_d        = NOP;
        alu_d       = '0;
        mem_rdata_d = '0;
        io_rdata_d  = '0;
        wb_reg_d    = '0;
        wb_enable_d = 1'b0;
        wb_src_d    = 2'b00;
        if (valid_in && !stall_out && !misaligned) begin
            pc_d        = pc_in;
            iw_d        = iw_in;
            alu_d       = alu_in;
            wb_reg_d    = wb_reg_in;
            wb_enable_d = wb_enable_in & ~is_store & (wb_reg_in != 5'd0);
            if (mem_op) begin
                wb_src_d = is_io ? 2'b10 : 2'b01;
                if (is_io) io_rdata_d  = dbus_rdata;
                else       mem_rdata_d = dbus_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= '0;
            iw_q        <= NOP;
            alu_q       <= '0;
            mem_rdata_q <= '0;
            io_rdata_q  <= '0;
            wb_reg_q    <= '0;
            wb_enable_q <= 1'b0;
            wb_src_q    <= 2'b00;
        end else begin
            pc_q        <= pc_d;
            iw_q        <= iw_d;
            alu_q       <= alu_d;
            mem_rdata_q <= mem_rdata_d;
            io_rdata_q  <= io_rdata_d;
            wb_reg_q    <= wb_reg_d;
            wb_enable_q <= wb_enable_d;
            wb_src_q    <= wb_src_d;
        end
    end

    assign pc_out        = pc_q;
    assign iw_out        = iw_q;
    assign alu_out       = alu_q;
    assign mem_rdata_out = mem_rdata_q;
    assign io_rdata_out  = io_rdata_q;
    assign wb_reg_out    = wb_reg_q;
    assign wb_enable_out = wb_enable_q;
    assign wb_src_out    = wb_src_q;

    // ---------------- misalignment report ----------------
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    logic        misalign_d, misalign_q;
    logic [31:0] misalign_addr_d, misalign_addr_q;

    always_comb begin
        misalign_d      = misaligned;
        misalign_addr_d = misaligned ? alu_in : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign misalign_out  = misalign_q;
    assign misalign_addr = misalign_addr_q;
`else
    assign misalign_out  = 1'b0;
    assign misalign_addr = '0;
`endif

endmodule

// File: tb/tb_rv32_mem_top.sv
// Self-checking bench for rv32_mem_top: directed scenarios plus randomized
// LOAD/STORE/ALU operations checked against a transaction-level model.
module tb_rv32_mem_top;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
    logic [4:0]  wb_reg_in;
    logic        wb_enable_in;
    logic        dbus_req, dbus_we, dbus_io;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic [31:0] pc_out, iw_out, alu_out, mem_rdata_out, io_rdata_out;
    logic [4:0]  wb_reg_out;
    logic        wb_enable_out;
    logic [1:0]  wb_src_out;
    logic        stall_out;
    logic        df_mem_enable;
    logic [4:0]  df_mem_reg;
    logic [31:0] df_mem_data;
    logic        df_mem_is_load;
    logic        misalign_out;
    logic [31:0] misalign_addr;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    rv32_mem_top dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in),
        .rs2_data_in(rs2_data_in), .wb_reg_in(wb_reg_in), .wb_enable_in(wb_enable_in),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_io(dbus_io),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .pc_out(pc_out), .iw_out(iw_out), .alu_out(alu_out),
        .mem_rdata_out(mem_rdata_out), .io_rdata_out(io_rdata_out),
        .wb_reg_out(wb_reg_out), .wb_enable_out(wb_enable_out), .wb_src_out(wb_src_out),
        .stall_out(stall_out),
        .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg),
        .df_mem_data(df_mem_data), .df_mem_is_load(df_mem_is_load),
        .misalign_out(misalign_out), .misalign_addr(misalign_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: one instruction presented by EX, bus answers
    // after 'delay' wait cycles with 'rdata'. Called 1 time unit after a posedge.
    task automatic run_op(input logic [31:0] iw, input logic [31:0] pc,
                          input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] wreg, input logic wen,
                          input int unsigned delay, input logic [31:0] rdata);
        logic        ld, st, mem, io, mis, e_req, e_wen;
        int unsigned nb;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [1:0]  e_src;

        ld  = (iw[6:0] == 7'h03);
        st  = (iw[6:0] == 7'h23);
        mem = ld | st;
        io  = alu[31];
        nb  = (iw[13:12] == 2'd0) ? 1 : (iw[13:12] == 2'd1) ? 2 : 4;
        mis = 1'b0;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
        mis = mem && ((alu % nb) != 0);
`endif
        e_req = mem && !mis;
        // lanes of the naturally aligned container holding the access
        e_be  = 4'(((1 << nb) - 1) << ((alu % 4) - (alu % nb)));
        if (!st)          e_wd = 32'h0;
        else if (nb == 4) e_wd = rs2;
        else if (nb == 2) e_wd = (rs2 & 32'hFFFF) * 32'h0001_0001;
        else              e_wd = (rs2 & 32'hFF) * 32'h0101_0101;
        e_wen = wen && !st && (wreg != 0) && !mis;
        e_src = !mem ? 2'd0 : (io ? 2'd2 : 2'd1);

        valid_in     = 1'b1;
        iw_in        = iw;
        pc_in        = pc;
        alu_in       = alu;
        rs2_data_in  = rs2;
        wb_reg_in    = wreg;
        wb_enable_in = wen;
        dbus_rdata   = rdata;
        dbus_ack     = e_req && (delay == 0);
        #1;
        chk("df_enable", df_mem_enable, wen && (wreg != 0));
        chk("df_reg", df_mem_reg, wreg);
        chk("df_data", df_mem_data, alu);
        chk("df_is_load", df_mem_is_load, ld);
        chk("dbus_req", dbus_req, e_req);
        if (e_req) begin
            chk("dbus_addr", dbus_addr, alu & 32'hFFFF_FFFC);
            chk("dbus_be", dbus_be, e_be);
            chk("dbus_wdata", dbus_wdata, e_wd);
            chk("dbus_we", dbus_we, st);
            chk("dbus_io", dbus_io, io);
            for (int unsigned i = 0; i < delay; i++) begin
                chk("wait_stall", stall_out, 1'b1);
                chk("wait_req", dbus_req, 1'b1);
                chk("wait_addr", dbus_addr, alu & 32'hFFFF_FFFC);
                chk("wait_be", dbus_be, e_be);
                chk("wait_wdata", dbus_wdata, e_wd);
                @(posedge clk); #1;
                chk("bubble_iw", iw_out, NOP);
                chk("bubble_wen", wb_enable_out, 1'b0);
            end
            dbus_ack = 1'b1;
            #1;
        end
        chk("stall_done", stall_out, 1'b0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        dbus_ack = 1'b0;
        if (mis) begin
            chk("mis_out", misalign_out, 1'b1);
            chk("mis_addr", misalign_addr, alu);
            chk("mis_wen", wb_enable_out, 1'b0);
            chk("mis_iw", iw_out, NOP);
        end else begin
            chk("wb_pc", pc_out, pc);
            chk("wb_iw", iw_out, iw);
            chk("wb_alu", alu_out, alu);
            chk("wb_reg", wb_reg_out, wreg);
            chk("wb_en", wb_enable_out, e_wen);
            chk("wb_src", wb_src_out, e_src);
            chk("wb_mem_rdata", mem_rdata_out, (mem && !io) ? rdata : 32'h0);
            chk("wb_io_rdata", io_rdata_out, (mem && io) ? rdata : 32'h0);
            chk("mis_idle", misalign_out, 1'b0);
        end
        @(posedge clk); #1;
        chk("after_mis", misalign_out, 1'b0);
        chk("after_wen", wb_enable_out, 1'b0);
    endtask

    logic [31:0] r_iw, r_alu;
    int unsigned kind;

    initial begin
        reset = 1'b0;
        valid_in = 1'b1;  // memory op presented during reset must not request
        iw_in = {17'h0, 3'b010, 5'd6, 7'h03};
        pc_in = 32'h10; alu_in = 32'h300; rs2_data_in = '0;
        wb_reg_in = 5'd6; wb_enable_in = 1'b1;
        dbus_ack = 1'b0; dbus_rdata = '0;
        #12;
        chk("rst_req", dbus_req, 1'b0);
        chk("rst_stall", stall_out, 1'b0);
        chk("rst_mis", misalign_out, 1'b0);
        chk("rst_iw", iw_out, NOP);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_alu", alu_out, 32'h0);
        chk("rst_mrd", mem_rdata_out, 32'h0);
        chk("rst_iord", io_rdata_out, 32'h0);
        chk("rst_reg", wb_reg_out, 5'd0);
        chk("rst_wen", wb_enable_out, 1'b0);
        chk("rst_src", wb_src_out, 2'd0);
        valid_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // SW x5 to 0x104, ack same cycle
        run_op({7'h0, 5'd5, 5'd1, 3'b010, 5'd3, 7'h23}, 32'h100, 32'h104,
               32'hDEAD_BEEF, 5'd3, 1'b1, 0, 32'h0);
        // LB at 0x203, 3 wait cycles
        run_op({17'h0, 3'b000, 5'd9, 7'h03}, 32'h104, 32'h203,
               32'h0, 5'd9, 1'b1, 3, 32'h1122_3344);
        // SH at 0x12
        run_op({7'h0, 5'd4, 5'd2, 3'b001, 5'd0, 7'h23}, 32'h108, 32'h12,
               32'h1234_ABCD, 5'd0, 1'b0, 0, 32'h0);
        // LW from IO region
        run_op({17'h0, 3'b010, 5'd4, 7'h03}, 32'h10C, 32'h8000_0010,
               32'h0, 5'd4, 1'b1, 1, 32'hCAFE_F00D);
        // ADD x7 and ADD x0
        run_op({7'h0, 5'd2, 5'd1, 3'b000, 5'd7, 7'h33}, 32'h110, 32'h55,
               32'h0, 5'd7, 1'b1, 0, 32'h0);
        run_op({7'h0, 5'd2, 5'd1, 3'b000, 5'd0, 7'h33}, 32'h114, 32'h66,
               32'h0, 5'd0, 1'b1, 0, 32'h0);
        // LW at misaligned 0x102
        run_op({17'h0, 3'b010, 5'd8, 7'h03}, 32'h118, 32'h102,
               32'h0, 5'd8, 1'b1, 0, 32'h5555_AAAA);

        // Reset during the second WAIT cycle aborts the access
        valid_in = 1'b1;
        iw_in = {17'h0, 3'b010, 5'd6, 7'h03};
        pc_in = 32'h11C; alu_in = 32'h200; wb_reg_in = 5'd6; wb_enable_in = 1'b1;
        dbus_ack = 1'b0; dbus_rdata = 32'h7777_7777;
        #1;
        chk("abort_req0", dbus_req, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_stall", stall_out, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort_req", dbus_req, 1'b0);
        chk("abort_stall_low", stall_out, 1'b0);
        chk("abort_iw", iw_out, NOP);
        chk("abort_wen", wb_enable_out, 1'b0);
        valid_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        dbus_ack = 1'b1;  // late ack, nothing outstanding
        #1;
        chk("late_req", dbus_req, 1'b0);
        chk("late_stall", stall_out, 1'b0);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        chk("late_wen", wb_enable_out, 1'b0);
        chk("late_iw", iw_out, NOP);
        chk("late_mrd", mem_rdata_out, 32'h0);
        // a following non-memory op must see an idle bus
        run_op({7'h0, 5'd3, 5'd2, 3'b000, 5'd10, 7'h13}, 32'h120, 32'h99,
               32'h0, 5'd10, 1'b1, 0, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            kind  = $urandom_range(0, 2);
            r_iw  = $urandom;
            r_alu = $urandom;
            case (kind)
                0: begin
                    r_iw[6:0] = 7'h03;
                    case ($urandom_range(0, 4))
                        0: r_iw[14:12] = 3'b000;
                        1: r_iw[14:12] = 3'b001;
                        2: r_iw[14:12] = 3'b010;
                        3: r_iw[14:12] = 3'b100;
                        default: r_iw[14:12] = 3'b101;
                    endcase
                end
                1: begin
                    r_iw[6:0]   = 7'h23;
                    r_iw[14:12] = 3'($urandom_range(0, 2));
                end
                default: r_iw[6:0] = ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13;
            endcase
            run_op(r_iw, $urandom, r_alu, $urandom, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32_mem_top.md
RV32_MEM_TOP -- requirements
Module: rv32_mem_top

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low; low forces the reset state immediately.
REQ-003 SHALL have inputs from EX: valid_in 1, pc_in 32, iw_in 32, alu_in 32 (result or effective address), rs2_data_in 32 (store data), wb_reg_in 5, wb_enable_in 1.
REQ-004 SHALL have the data-bus master ports dbus_req out 1, dbus_we out 1, dbus_io out 1 (1 = IO region), dbus_addr out 32, dbus_be out 4, dbus_wdata out 32, dbus_ack in 1, dbus_rdata in 32.
REQ-005 SHALL have the registered outputs to WB: pc_out 32, iw_out 32, alu_out 32, mem_rdata_out 32, io_rdata_out 32, wb_reg_out 5, wb_enable_out 1, wb_src_out 2 (00 ALU, 01 mem, 10 IO).
REQ-006 SHALL have stall_out out 1, which holds EX and earlier stages.
REQ-007 SHALL have forwarding outputs df_mem_enable 1, df_mem_reg 5, df_mem_data 32, df_mem_is_load 1.
REQ-008 SHALL have misalign_out out 1 and misalign_addr out 32.

Function
REQ-009 SHALL decode LOAD (opcode 0000011) and STORE (0100011) from iw_in; every other opcode is non-memory.
REQ-010 SHALL treat alu_in[31]=1 as the IO region (dbus_io=1, wb_src 10) and alu_in[31]=0 as memory (wb_src 01); non-memory instructions use wb_src 00.
REQ-011 SHALL drive dbus_addr = {alu_in[31:2],2'b00}.
REQ-012 SHALL generate byte enables: SB/LB/LBU 0001<<alu_in[1:0]; SH/LH/LHU 0011<<(2*alu_in[1]); SW/LW 1111.
REQ-013 SHALL drive dbus_wdata as the replicated byte for SB, the replicated halfword for SH and rs2_data_in for SW; it is 0 for loads.
REQ-014 SHALL implement FSM IDLE/WAIT. In IDLE, a valid memory instruction asserts dbus_req combinationally in the same cycle. If dbus_ack is also high, the access completes in that cycle; otherwise the FSM goes to WAIT.
REQ-015 In WAIT, the block SHALL hold dbus_req and all dbus_* outputs stable and keep stall_out=1. On dbus_ack it SHALL complete the access and return to IDLE.
REQ-016 stall_out SHALL equal (memory access in progress) AND NOT dbus_ack.
REQ-017 On completion, or for a valid non-memory instruction, the WB register SHALL load all inputs in the next edge (latency 1). dbus_rdata is captured into mem_rdata_out or io_rdata_out per region; the other read-data output is written 0.
REQ-018 While stalled, or when valid_in=0, the WB register SHALL load a bubble: wb_enable_out=0, iw_out=NOP 0x00000013.
REQ-019 SHALL force wb_enable_out=0 for stores and whenever wb_reg_in=0.
REQ-020 SHALL drive the df_mem_* outputs combinationally from the current inputs: enable=valid_in&wb_enable_in&(wb_reg_in!=0), data=alu_in, is_load=LOAD&valid_in.
REQ-021 An ack arriving while not in an access SHALL be ignored.

Reset
REQ-022 With reset low: FSM=IDLE, and all WB-register outputs are 0 except iw_out=0x00000013. dbus_req, stall_out and misalign_out are 0.
REQ-023 Reset asserted during WAIT SHALL abort the access immediately (dbus_req low asynchronously); no WB write results.

Configuration
REQ-024 Macro RV32_MEM_MISALIGN_TRAP_EN.
- Defined: halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 issue no dbus_req. They produce a bubble, a 1-cycle misalign_out=1 and misalign_addr=alu_in, registered with the WB stage.
- Undefined: such accesses issue normally with the REQ-012 enables, and misalign_out and misalign_addr are tied to 0.

Verification
REQ-025 SW x5=0xDEADBEEF to 0x00000104, ack same cycle -> be=1111, addr 0x104, wdata 0xDEADBEEF, stall never high, wb_enable_out=0 next cycle.
REQ-026 LB at 0x00000203, ack after 3 wait cycles -> stall_out=1 for 3 cycles, dbus_* stable, be=1000. mem_rdata_out=dbus_rdata and wb_src_out=01 one cycle after ack; bubbles precede it.
REQ-027 SH 0xABCD at 0x00000012 -> be=1100, wdata 0xABCDABCD; LW at 0x80000010 -> dbus_io=1, wb_src_out=10, io_rdata_out captured.
REQ-028 ADD wb_reg 7, alu 0x55 -> df_mem_enable=1 same cycle, alu_out=0x55 and wb_enable_out=1 next cycle; with wb_reg 0 -> wb_enable_out=0.
REQ-029 Reset low during the second WAIT cycle -> dbus_req and stall_out drop immediately. After release: IDLE, iw_out=0x13, late ack ignored.
REQ-030 LW at 0x00000102 with the macro defined -> no dbus_req, misalign_out=1 for 1 cycle, misalign_addr=0x102; without the macro -> request at 0x100 with be=1111.
